// File: rtl/rpn_pkg.sv
// Shared types and codes for the RPN calculator: controller state/status
// encoding, error codes, and the opcode map the ALU decodes.
package rpn_pkg;

  typedef enum logic [2:0] {
    S_ENTER     = 3'd0,
    S_PUSH      = 3'd1,
    S_LOAD_OPS  = 3'd2,
    S_EXEC      = 3'd3,
    S_WRITEBACK = 3'd4,
    S_ERROR     = 3'd7
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OVF  = 2'd1;
  localparam logic [1:0] ERR_UNF  = 2'd2;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_OR  = 2'd3;

endpackage

// File: rtl/rpn_stack.sv
// Operand stack: register array plus fill count, with push, replace-and-pop
// (result lands at count-2) and clear. Exposes the top two entries.
module rpn_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             replacePop,
  input  logic             clear,
  input  logic [WIDTH-1:0] pushData,
  input  logic [WIDTH-1:0] replaceData,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] second,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (push && count != CW'(DEPTH)) begin
      count <= count + CW'(1);
    end else if (replacePop && count >= CW'(2)) begin
      count <= count - CW'(1);
    end
  end

  // Array contents are never reset; an empty stack is defined by count alone.
  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!clear) begin
        if (push && int'(count) == i) begin
          mem[i] <= pushData;
        end else if (replacePop && int'(count) == i + 2) begin
          mem[i] <= replaceData;
        end
      end
    end
  end

  always_comb begin
    top    = '0;
    second = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(count) == i + 1) top    = mem[i];
      if (int'(count) == i + 2) second = mem[i];
    end
  end

endmodule

// File: rtl/rpn_stack_ctrl.sv
// RPN calculator controller: sequences operand pushes and opcode execution
// against an external combinational ALU, with overflow/underflow trapping.
module rpn_stack_ctrl
  import rpn_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int OPW   = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enter_pulse,
  input  logic             is_op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [OPW-1:0]   opcode_in,
  input  logic             clear_pulse,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] alu_op_a,
  output logic [WIDTH-1:0] alu_op_b,
  output logic [OPW-1:0]   alu_opcode,
  output logic [WIDTH-1:0] top_value,
  output logic [CW-1:0]    depth_count,
  output logic [2:0]       status,
  output logic             result_valid,
  output logic             error,
  output logic [1:0]       err_code
);

  state_t           state;
  logic [WIDTH-1:0] capData;
  logic [OPW-1:0]   capOp;
  logic [WIDTH-1:0] stackTop;
  logic [WIDTH-1:0] stackSecond;
  logic [CW-1:0]    count;

  rpn_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) stackInst (
    .clock       (clock),
    .reset       (reset),
    .push        (state == S_PUSH),
    .replacePop  (state == S_WRITEBACK),
    .clear       (clear_pulse),
    .pushData    (capData),
    .replaceData (alu_result),
    .top         (stackTop),
    .second      (stackSecond),
    .count       (count)
  );

  // Entry capture registers carry data only, so they need no reset.
  always_ff @(posedge clock) begin
    if (state == S_ENTER && enter_pulse) begin
      capData <= data_in;
      capOp   <= opcode_in;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_ENTER;
      alu_op_a     <= '0;
      alu_op_b     <= '0;
      alu_opcode   <= '0;
      result_valid <= 1'b0;
      err_code     <= ERR_NONE;
    end else if (clear_pulse) begin
      state        <= S_ENTER;
      result_valid <= 1'b0;
      err_code     <= ERR_NONE;
    end else begin
      case (state)
        S_ENTER: begin
          if (enter_pulse && !is_op) begin
            if (count == CW'(DEPTH)) begin
              state    <= S_ERROR;
              err_code <= ERR_OVF;
            end else begin
              state <= S_PUSH;
            end
          end else if (enter_pulse && is_op) begin
            if (count < CW'(2)) begin
              state    <= S_ERROR;
              err_code <= ERR_UNF;
            end else begin
              state <= S_LOAD_OPS;
            end
          end
        end
        S_PUSH: begin
          result_valid <= 1'b0;
          state        <= S_ENTER;
        end
        S_LOAD_OPS: begin
          alu_op_a   <= stackSecond;
          alu_op_b   <= stackTop;
          alu_opcode <= capOp;
          state      <= S_EXEC;
        end
        S_EXEC:      state <= S_WRITEBACK;
        S_WRITEBACK: begin
          result_valid <= 1'b1;
          state        <= S_ENTER;
        end
        S_ERROR:     state <= S_ERROR;
        default:     state <= S_ENTER;
      endcase
    end
  end

  assign top_value   = stackTop;
  assign depth_count = count;
  assign status      = state;
  assign error       = (state == S_ERROR);

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Bench for rpn_stack_ctrl: table of entries with expected post-entry outputs
// routed through a scoreboard queue, plus sequences for reset/overflow/clear.
module tb_rpn_stack_ctrl;
  import rpn_pkg::*;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int OPW   = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             enter_pulse = 1'b0;
  logic             is_op = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic [OPW-1:0]   opcode_in = '0;
  logic             clear_pulse = 1'b0;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] alu_op_a;
  logic [WIDTH-1:0] alu_op_b;
  logic [OPW-1:0]   alu_opcode;
  logic [WIDTH-1:0] top_value;
  logic [CW-1:0]    depth_count;
  logic [2:0]       status;
  logic             result_valid;
  logic             error;
  logic [1:0]       err_code;

  rpn_stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OPW(OPW), .CW(CW)) dut (
    .clock        (clock),
    .reset        (reset),
    .enter_pulse  (enter_pulse),
    .is_op        (is_op),
    .data_in      (data_in),
    .opcode_in    (opcode_in),
    .clear_pulse  (clear_pulse),
    .alu_result   (alu_result),
    .alu_op_a     (alu_op_a),
    .alu_op_b     (alu_op_b),
    .alu_opcode   (alu_opcode),
    .top_value    (top_value),
    .depth_count  (depth_count),
    .status       (status),
    .result_valid (result_valid),
    .error        (error),
    .err_code     (err_code)
  );

  always #5 clock = ~clock;

  // Reference ALU: truncating WIDTH-bit arithmetic.
  always_comb begin
    case (alu_opcode)
      OP_ADD:  alu_result = alu_op_a + alu_op_b;
      OP_SUB:  alu_result = alu_op_a - alu_op_b;
      OP_AND:  alu_result = alu_op_a & alu_op_b;
      default: alu_result = alu_op_a | alu_op_b;
    endcase
  end

  typedef struct {
    int         kind;     // 0 operand, 1 opcode, 2 clear
    logic [15:0] val;
    logic [15:0] eTop;
    int         eDepth;
    int         eStatus;
    int         eErr;
    int         eCode;
    int         eRv;
  } vec_t;

  vec_t tbl[$];
  vec_t expQ[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic addVec(input int kind, input logic [15:0] val, input logic [15:0] eTop,
                        input int eDepth, input int eStatus, input int eErr,
                        input int eCode, input int eRv);
    vec_t v;
    v.kind = kind; v.val = val; v.eTop = eTop; v.eDepth = eDepth;
    v.eStatus = eStatus; v.eErr = eErr; v.eCode = eCode; v.eRv = eRv;
    tbl.push_back(v);
  endtask

  task automatic pushOperand(input logic [15:0] val);
    enter_pulse = 1'b1; is_op = 1'b0; data_in = val;
    tick();
    enter_pulse = 1'b0;
    tick();
  endtask

  task automatic applyEntry(input int kind, input logic [15:0] val);
    if (kind == 0) begin
      pushOperand(val);
    end else if (kind == 1) begin
      enter_pulse = 1'b1; is_op = 1'b1; opcode_in = val[1:0];
      tick();
      enter_pulse = 1'b0; is_op = 1'b0;
      repeat (3) tick();
    end else begin
      clear_pulse = 1'b1;
      tick();
      clear_pulse = 1'b0;
      tick();
    end
  endtask

  task automatic compareOut(input vec_t e, input int idx);
    string t;
    t = $sformatf("vec%0d", idx);
    check({t, ".top_value"},    32'(top_value),    32'(e.eTop));
    check({t, ".depth_count"},  32'(depth_count),  32'(e.eDepth));
    check({t, ".status"},       32'(status),       32'(e.eStatus));
    check({t, ".error"},        32'(error),        32'(e.eErr));
    check({t, ".err_code"},     32'(err_code),     32'(e.eCode));
    check({t, ".result_valid"}, 32'(result_valid), 32'(e.eRv));
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, ".status"},       32'(status),       32'd0);
    check({tag, ".depth_count"},  32'(depth_count),  32'd0);
    check({tag, ".top_value"},    32'(top_value),    32'd0);
    check({tag, ".alu_op_a"},     32'(alu_op_a),     32'd0);
    check({tag, ".alu_op_b"},     32'(alu_op_b),     32'd0);
    check({tag, ".alu_opcode"},   32'(alu_opcode),   32'd0);
    check({tag, ".result_valid"}, 32'(result_valid), 32'd0);
    check({tag, ".error"},        32'(error),        32'd0);
    check({tag, ".err_code"},     32'(err_code),     32'd0);
  endtask

  initial begin
    vec_t e;

    // kind, value, top, depth, status, error, err_code, result_valid
    addVec(2, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);
    addVec(0, 16'h0005, 16'h0005, 1, 0, 0, 0, 0);
    addVec(0, 16'h0003, 16'h0003, 2, 0, 0, 0, 0);
    addVec(1, 16'(OP_ADD), 16'h0008, 1, 0, 0, 0, 1);
    addVec(2, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);
    addVec(0, 16'h0002, 16'h0002, 1, 0, 0, 0, 0);
    addVec(0, 16'h0003, 16'h0003, 2, 0, 0, 0, 0);
    addVec(0, 16'h0004, 16'h0004, 3, 0, 0, 0, 0);
    addVec(1, 16'(OP_SUB), 16'hFFFF, 2, 0, 0, 0, 1);
    addVec(1, 16'(OP_ADD), 16'h0001, 1, 0, 0, 0, 1);
    addVec(2, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);
    addVec(0, 16'hF0F0, 16'hF0F0, 1, 0, 0, 0, 0);
    addVec(0, 16'h0FF0, 16'h0FF0, 2, 0, 0, 0, 0);
    addVec(1, 16'(OP_AND), 16'h00F0, 1, 0, 0, 0, 1);
    addVec(0, 16'h1234, 16'h1234, 2, 0, 0, 0, 0);
    addVec(1, 16'(OP_OR), 16'h12F4, 1, 0, 0, 0, 1);
    addVec(2, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);
    addVec(0, 16'h0007, 16'h0007, 1, 0, 0, 0, 0);
    addVec(1, 16'(OP_ADD), 16'h0007, 1, 7, 1, 2, 0);
    addVec(0, 16'h0009, 16'h0007, 1, 7, 1, 2, 0);
    addVec(1, 16'(OP_SUB), 16'h0007, 1, 7, 1, 2, 0);
    addVec(2, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);
    addVec(1, 16'(OP_SUB), 16'h0000, 0, 7, 1, 2, 0);
    addVec(2, 16'h0000, 16'h0000, 0, 0, 0, 0, 0);

    repeat (2) tick();
    checkResetOutputs("in_reset");
    reset = 1'b1;
    tick();
    checkResetOutputs("after_release");

    for (int i = 0; i < tbl.size(); i++) begin
      expQ.push_back(tbl[i]);
      applyEntry(tbl[i].kind, tbl[i].val);
      if (expQ.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL scoreboard_empty: got no entry at vec%0d, expected one", i);
      end else begin
        e = expQ.pop_front();
        compareOut(e, i);
      end
    end

    // Operand capture into the ALU, then async reset during WRITEBACK.
    pushOperand(16'h0005);
    pushOperand(16'h0003);
    enter_pulse = 1'b1; is_op = 1'b1; opcode_in = OP_ADD;
    tick();
    enter_pulse = 1'b0; is_op = 1'b0;
    check("load.status", 32'(status), 32'd2);
    tick();
    check("exec.alu_op_a",   32'(alu_op_a),   32'h5);
    check("exec.alu_op_b",   32'(alu_op_b),   32'h3);
    check("exec.alu_opcode", 32'(alu_opcode), 32'(OP_ADD));
    tick();
    check("wb.status", 32'(status), 32'd4);
    #2 reset = 1'b0;
    #1 checkResetOutputs("async_reset_mid_wb");
    #1 reset = 1'b1;
    tick();
    checkResetOutputs("after_mid_wb_reset");

    // Overflow: ninth push traps with the stack frozen full.
    for (int i = 1; i <= 9; i++) pushOperand(16'(i * 16));
    check("ovf.status",      32'(status),      32'd7);
    check("ovf.error",       32'(error),       32'd1);
    check("ovf.err_code",    32'(err_code),    32'd1);
    check("ovf.depth_count", 32'(depth_count), 32'd8);
    check("ovf.top_value",   32'(top_value),   32'h80);
    applyEntry(1, 16'(OP_ADD));
    check("ovf_ignored.depth_count", 32'(depth_count), 32'd8);
    check("ovf_ignored.status",      32'(status),      32'd7);
    applyEntry(2, 16'h0);
    check("ovf_clear.depth_count", 32'(depth_count), 32'd0);
    check("ovf_clear.error",       32'(error),       32'd0);
    check("ovf_clear.err_code",    32'(err_code),    32'd0);

    // Clear wins over a simultaneous operand entry.
    pushOperand(16'h0011);
    pushOperand(16'h0022);
    pushOperand(16'h0033);
    check("pre_clear.depth_count", 32'(depth_count), 32'd3);
    clear_pulse = 1'b1; enter_pulse = 1'b1; is_op = 1'b0; data_in = 16'h00AA;
    tick();
    clear_pulse = 1'b0; enter_pulse = 1'b0;
    check("clr_enter.status_next", 32'(status), 32'd0);
    tick();
    check("clr_enter.depth_count", 32'(depth_count), 32'd0);
    check("clr_enter.status",      32'(status),      32'd0);
    check("clr_enter.top_value",   32'(top_value),   32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
